// File: rtl/pc_pkg.sv
// Shared constants and enums for the fetch PC generator.
package pc_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_PEND,
        SRC_BR,
        SRC_JR,
        SRC_ERET,
        SRC_EXC
    } pc_src_e;

    typedef enum logic {
        IDLE,
        PEND
    } pend_state_e;

endpackage

// File: rtl/pc_sel.sv
// Fixed-priority next-PC source select: exc > eret > jr > br > pending > sequential.
module pc_sel
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter logic [WIDTH-1:0] EXC_PC = EXC_PC_DEF[WIDTH-1:0]
) (
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic             jr_valid,
    input  logic             br_valid,
    input  logic             pend_valid,
    input  logic [WIDTH-1:0] epc,
    input  logic [WIDTH-1:0] jr_target,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] pend_target,
    input  logic [WIDTH-1:0] pc_plus,
    output pc_src_e          src,
    output logic [WIDTH-1:0] target
);

    always_comb begin
        src    = SRC_SEQ;
        target = pc_plus;
        if (exc_valid) begin
            src    = SRC_EXC;
            target = EXC_PC;
        end else if (eret_valid) begin
            src    = SRC_ERET;
            target = epc;
        end else if (jr_valid) begin
            src    = SRC_JR;
            target = jr_target;
        end else if (br_valid) begin
            src    = SRC_BR;
            target = br_target;
        end else if (pend_valid) begin
            src    = SRC_PEND;
            target = pend_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with stall and buffered redirect.
// Optional PC_ALIGN_CHK_EN adds a registered misalign output.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF[WIDTH-1:0],
    parameter logic [WIDTH-1:0] EXC_PC   = EXC_PC_DEF[WIDTH-1:0],
    parameter int unsigned      PC_STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jr_valid,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
`ifdef PC_ALIGN_CHK_EN
    output logic             misalign,
`endif
    output logic             pend_valid
);

    pend_state_e      state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    pc_src_e          src;
    logic [WIDTH-1:0] sel_target;

    assign pc         = pc_q;
    assign pc_plus    = pc_q + WIDTH'(PC_STEP);
    assign pend_valid = (state_q == PEND);

    pc_sel #(
        .WIDTH  (WIDTH),
        .EXC_PC (EXC_PC)
    ) u_pc_sel (
        .exc_valid   (exc_valid),
        .eret_valid  (eret_valid),
        .jr_valid    (jr_valid),
        .br_valid    (br_valid),
        .pend_valid  (pend_valid),
        .epc         (epc),
        .jr_target   (jr_target),
        .br_target   (br_target),
        .pend_target (pend_tgt_q),
        .pc_plus     (pc_plus),
        .src         (src),
        .target      (sel_target)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        if (src == SRC_EXC || src == SRC_ERET) begin
            // Flush wins over stall and drops any buffered redirect.
            pc_d    = sel_target;
            state_d = IDLE;
        end else if (stall) begin
            if (src == SRC_JR || src == SRC_BR) begin
                pend_tgt_d = sel_target;
                state_d    = PEND;
            end
        end else begin
            pc_d    = sel_target;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= |RESET_PC[1:0];
        end else begin
            misalign_q <= |pc_d[1:0];
        end
    end

    assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; misalign checks are active when PC_ALIGN_CHK_EN is defined.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, stall, br_valid, jr_valid, exc_valid, eret_valid;
    logic [31:0] br_target, jr_target, epc;
    logic [31:0] pc, pc_plus;
    logic        pend_valid;
`ifdef PC_ALIGN_CHK_EN
    logic        misalign;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_3000),
        .EXC_PC   (32'h0000_4180),
        .PC_STEP  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .jr_valid   (jr_valid),
        .jr_target  (jr_target),
        .exc_valid  (exc_valid),
        .eret_valid (eret_valid),
        .epc        (epc),
        .pc         (pc),
        .pc_plus    (pc_plus),
`ifdef PC_ALIGN_CHK_EN
        .misalign   (misalign),
`endif
        .pend_valid (pend_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic exp_pend);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".pend"}, {31'b0, pend_valid}, {31'b0, exp_pend});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_valid = 1'b0; jr_valid = 1'b0;
        exc_valid = 1'b0; eret_valid = 1'b0;
        br_target = '0; jr_target = '0; epc = '0;
        step(); step();
        chk_pc("reset", 32'h3000, 1'b0);
        check("reset.pc_plus", pc_plus, 32'h3004);
`ifdef PC_ALIGN_CHK_EN
        check("reset.misalign", {31'b0, misalign}, 32'h0);
`endif

        reset = 1'b0;
        step(); chk_pc("seq1", 32'h3004, 1'b0);
        step(); chk_pc("seq2", 32'h3008, 1'b0);
        step(); chk_pc("seq3", 32'h300C, 1'b0);
        step(); chk_pc("seq4", 32'h3010, 1'b0);

        br_valid = 1'b1; br_target = 32'h3400;
        step(); chk_pc("br", 32'h3400, 1'b0);
        br_valid = 1'b0;
        step(); chk_pc("br.next", 32'h3404, 1'b0);

        // stall 3 cycles: jr in cycle 1, br in cycle 2 (newest wins)
        stall = 1'b1; jr_valid = 1'b1; jr_target = 32'h3800;
        step(); chk_pc("stall.c1", 32'h3404, 1'b1);
        jr_valid = 1'b0; br_valid = 1'b1; br_target = 32'h3900;
        step(); chk_pc("stall.c2", 32'h3404, 1'b1);
        br_valid = 1'b0;
        step(); chk_pc("stall.c3", 32'h3404, 1'b1);
        stall = 1'b0;
        step(); chk_pc("release", 32'h3900, 1'b0);
        step(); chk_pc("release.next", 32'h3904, 1'b0);

        // wraparound
        br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
        step(); chk_pc("wrap.pc", 32'hFFFF_FFFC, 1'b0);
        check("wrap.pc_plus", pc_plus, 32'h0);
        br_valid = 1'b0;
        step(); chk_pc("wrap.next", 32'h0, 1'b0);

        // exception during stall with pending redirect
        stall = 1'b1; br_valid = 1'b1; br_target = 32'h3A00;
        step(); chk_pc("exc.pend", 32'h0, 1'b1);
        br_valid = 1'b0; exc_valid = 1'b1;
        step(); chk_pc("exc", 32'h4180, 1'b0);
        exc_valid = 1'b0; stall = 1'b0;
        step(); chk_pc("exc.next", 32'h4184, 1'b0);

        // new redirect in release cycle beats pending
        stall = 1'b1; br_valid = 1'b1; br_target = 32'h3B00;
        step(); chk_pc("rel.pend", 32'h4184, 1'b1);
        br_valid = 1'b0; stall = 1'b0; jr_valid = 1'b1; jr_target = 32'h3C00;
        step(); chk_pc("rel.new", 32'h3C00, 1'b0);
        jr_valid = 1'b0;
        step(); chk_pc("rel.next", 32'h3C04, 1'b0);

        // exc + eret + br together, then eret alone
        exc_valid = 1'b1; eret_valid = 1'b1; epc = 32'h3050;
        br_valid = 1'b1; br_target = 32'h3D00;
        step(); chk_pc("prio.exc", 32'h4180, 1'b0);
        exc_valid = 1'b0; br_valid = 1'b0;
        step(); chk_pc("prio.eret", 32'h3050, 1'b0);
        eret_valid = 1'b0;
        step(); chk_pc("eret.next", 32'h3054, 1'b0);

        // stall with no redirect holds everything
        stall = 1'b1;
        step(); chk_pc("hold1", 32'h3054, 1'b0);
        step(); chk_pc("hold2", 32'h3054, 1'b0);

        // reset mid-stall discards pending
        br_valid = 1'b1; br_target = 32'h3E00;
        step(); chk_pc("rst.pend", 32'h3054, 1'b1);
        br_valid = 1'b0; reset = 1'b1;
        step(); chk_pc("rst", 32'h3000, 1'b0);
        reset = 1'b0; stall = 1'b0;
        step(); chk_pc("rst.next", 32'h3004, 1'b0);

        // misaligned target loads unmodified
        br_valid = 1'b1; br_target = 32'h3402;
        step(); chk_pc("mis.pc", 32'h3402, 1'b0);
`ifdef PC_ALIGN_CHK_EN
        check("mis.flag1", {31'b0, misalign}, 32'h1);
`endif
        br_target = 32'h3404;
        step(); chk_pc("al.pc", 32'h3404, 1'b0);
`ifdef PC_ALIGN_CHK_EN
        check("mis.flag0", {31'b0, misalign}, 32'h0);
`endif
        br_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
